i2c_burst_engine: RTL and testbench
===================================

I2C_BURST_ENGINE -- requirements
Module: i2c_burst_engine

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4: maximum data bytes per burst (1..16).
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_BYTES+1): width of n_bytes.
REQ-003 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port timebase  in  1  bit-slot strobe; each 0->1 transition (sampled on clock) is one "tick".
REQ-006 SHALL have port start  in  1  single-cycle request to begin a burst; accepted only in IDLE.
REQ-007 SHALL have port direction  in  1  0 = write, 1 = read; latched at start.
REQ-008 SHALL have port slave_address  in  7  target address; latched at start.
REQ-009 SHALL have port n_bytes  in  CNT_W  data bytes in the burst; latched at start; values above MAX_BYTES are clamped to MAX_BYTES.
REQ-010 SHALL have port tx_data  in  8*MAX_BYTES  write payload; byte k = tx_data[8k+7:8k]; latched at start.
REQ-011 SHALL have port sda_in  in  1  sampled SDA line.
REQ-012 SHALL have port sda_out  out  1  SDA drive value.
REQ-013 SHALL have port sda_oe  out  1  1 = engine drives SDA; 0 = released.
REQ-014 SHALL have port busy  out  1  high from the cycle after start acceptance until the DONE cycle inclusive.
REQ-015 SHALL have port transfer_done  out  1  one-cycle pulse at burst end.
REQ-016 SHALL have port ack_error  out  1  sticky per burst; set on NACK; cleared at next start acceptance.
REQ-017 SHALL have port rx_data  out  8*MAX_BYTES  read payload, same byte order as tx_data; unreceived bytes hold 0.

Function
REQ-018 SHALL detect ticks internally (registered timebase, tick = timebase & ~previous); a tick's effects appear on outputs one clock later.
REQ-019 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, DONE.
REQ-020 IDLE: sda_oe=0, sda_out=0; start moves to ADDR and clears the bit and byte counters, rx_data and ack_error.
REQ-021 ADDR: on each of 8 ticks, drive the next bit of {slave_address, direction}, MSB first, with sda_oe=1; the 9th tick enters ADDR_ACK and releases SDA.
REQ-022 ADDR_ACK: the next tick samples sda_in; 1 (NACK) sets ack_error and enters DONE; 0 enters DATA, or DONE if n_bytes==0.
REQ-023 DATA write: drive byte k MSB first, one bit per tick, sda_oe=1; after 8 bits, release SDA and enter DATA_ACK; the next tick samples ACK exactly as in REQ-022.
REQ-024 DATA read: sda_oe=0; sample sda_in on each tick into byte k MSB first; in DATA_ACK drive sda_oe=1, sda_out=0 (ACK), except the last byte, which drives sda_out=1 (NACK).
REQ-025 After DATA_ACK: increment k; enter DATA if k < latched count, else DONE.
REQ-026 DONE: assert transfer_done for exactly one clock, then return to IDLE; busy deasserts in the IDLE cycle.
REQ-027 A burst SHALL consume exactly 9*(1+count) ticks after start, absent NACK.
REQ-028 SHALL ignore start while not in IDLE, and ignore tx_data and n_bytes changes after latching.
REQ-029 A tick in the same cycle as start acceptance SHALL NOT count toward the burst.
REQ-030 SHALL leave rx_data unchanged and valid from DONE until the next start acceptance.

Reset
REQ-031 reset SHALL force IDLE, sda_oe=0, sda_out=0, busy=0, transfer_done=0, ack_error=0, rx_data=0, all counters and the previous-timebase register=0, including mid-burst.
REQ-032 reset SHALL take precedence over start in the same cycle.

Configuration
REQ-033 With I2C_BURST_ACK_CHECK_EN defined, NACK handling SHALL be as in REQ-022/REQ-023.
REQ-034 Without I2C_BURST_ACK_CHECK_EN, ACK slots SHALL still be released and timed, sda_in SHALL be ignored in ACK slots, ack_error SHALL be tied to 0, and every burst SHALL run to full length.

Structure
REQ-035 Package i2c_burst_pkg SHALL hold the state enum and the constants I2C_ACK=0, I2C_NACK=1, and BITS_PER_BYTE=8.
REQ-036 Tick detection SHALL be the sub-module timebase_edge_detect (ports clock, reset, timebase, tick).

Verification
REQ-037 Write test: address 0x50, n_bytes=2, tx_data=0xBEEF, sda_in=0 at all ACKs. SDA bit stream SHALL be A0, EF, BE with ACK gaps; transfer_done SHALL pulse after 27 ticks; ack_error=0.
REQ-038 Read test: address 0x51, n_bytes=3, slave returns 0x12, 0x34, 0x56. rx_data SHALL be 0x563412; master drives ACK, ACK, NACK.
REQ-039 NACK test: address NACK (sda_in=1) with n_bytes=4. DONE SHALL follow after 9 ticks, ack_error=1, and no data bits are driven; with the macro undefined, 45 ticks and ack_error=0.
REQ-040 Boundary test: n_bytes=0 SHALL yield 9 ticks; n_bytes=15 with MAX_BYTES=4 SHALL yield 45 ticks.
REQ-041 Robustness test: start pulsed mid-burst SHALL be ignored. Reset asserted at tick 12 SHALL return to IDLE next cycle with sda_oe=0, and a fresh start SHALL run normally.

Source files
------------

// File: rtl/i2c_burst_pkg.sv
// Shared types and constants for the I2C burst engine.
package i2c_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        DONE
    } state_e;

    localparam logic        I2C_ACK       = 1'b0;
    localparam logic        I2C_NACK      = 1'b1;
    localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_burst_engine_timebase_edge_detect.sv
// Rising-edge detector for the bit-slot strobe; tick is high for the cycle in
// which timebase is first seen high.
module timebase_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic timebase,
    output logic tick
);

    logic timebase_q;
    logic timebase_d;

    assign timebase_d = timebase;
    assign tick       = timebase & ~timebase_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            timebase_q <= 1'b0;
        end else begin
            timebase_q <= timebase_d;
        end
    end

endmodule

// File: rtl/i2c_burst_engine.sv
// I2C master burst sequencer: address byte, then up to MAX_BYTES data bytes,
// one SDA bit slot per timebase tick. Define I2C_BURST_ACK_CHECK_EN to abort on NACK.
module i2c_burst_engine
    import i2c_burst_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           timebase,
    input  logic                           start,
    input  logic                           direction,
    input  logic [6:0]                     slave_address,
    input  logic [CNT_W-1:0]               n_bytes,
    input  logic [BITS_PER_BYTE*MAX_BYTES-1:0] tx_data,
    input  logic                           sda_in,
    output logic                           sda_out,
    output logic                           sda_oe,
    output logic                           busy,
    output logic                           transfer_done,
    output logic                           ack_error,
    output logic [BITS_PER_BYTE*MAX_BYTES-1:0] rx_data
);

    localparam int unsigned DATA_W = BITS_PER_BYTE * MAX_BYTES;
    localparam int unsigned BIT_W  = $clog2(BITS_PER_BYTE);
    localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               dir_q, dir_d;
    logic [7:0]         shift_q, shift_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               sda_out_q, sda_out_d;
    logic               sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ack_err_q, ack_err_d;

    logic               tick;
    logic               nack_c;
    logic               load_byte;
    logic               last_bit_c;
    logic               last_byte_c;
    logic [CNT_W-1:0]   next_byte_c;
    logic [IDX_W-1:0]   rx_idx;

    timebase_edge_detect u_edge (
        .clock    (clock),
        .reset    (reset),
        .timebase (timebase),
        .tick     (tick)
    );

`ifdef I2C_BURST_ACK_CHECK_EN
    assign nack_c = (sda_in == I2C_NACK);
`else
    assign nack_c = 1'b0;
`endif

    assign last_bit_c  = (bit_cnt_q == BIT_W'(BITS_PER_BYTE - 1));
    assign last_byte_c = (byte_cnt_q == count_q - CNT_W'(1));
    assign next_byte_c = byte_cnt_q + CNT_W'(1);
    assign rx_idx      = IDX_W'(32'(byte_cnt_q) * BITS_PER_BYTE);

    // Each byte frame: first bit is driven when the frame opens, then 8 ticks
    // of bit slots/release, then one ACK tick that opens the next frame.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        dir_d      = dir_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        sda_out_d  = sda_out_q;
        sda_oe_d   = sda_oe_q;
        ack_err_d  = ack_err_q;
        load_byte  = 1'b0;

        case (state_q)
            IDLE: begin
                sda_oe_d  = 1'b0;
                sda_out_d = 1'b0;
                if (start) begin
                    state_d    = ADDR;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    rx_d       = '0;
                    ack_err_d  = 1'b0;
                    dir_d      = direction;
                    count_d    = (n_bytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : n_bytes;
                    tx_d       = tx_data;
                    sda_oe_d   = 1'b1;
                    sda_out_d  = slave_address[6];
                    shift_d    = {slave_address[5:0], direction, 1'b0};
                end
            end
            ADDR: begin
                if (tick) begin
                    if (last_bit_c) begin
                        state_d   = ADDR_ACK;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        sda_out_d = 1'b0;
                    end else begin
                        sda_out_d = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ADDR_ACK: begin
                if (tick) begin
                    if (nack_c) begin
                        ack_err_d = 1'b1;
                        state_d   = DONE;
                    end else if (count_q == '0) begin
                        state_d = DONE;
                    end else begin
                        load_byte = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (dir_q) begin
                        rx_d[rx_idx +: BITS_PER_BYTE] = {rx_q[rx_idx +: BITS_PER_BYTE-1], sda_in};
                        if (last_bit_c) begin
                            state_d   = DATA_ACK;
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b1;
                            sda_out_d = last_byte_c ? I2C_NACK : I2C_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else if (last_bit_c) begin
                        state_d   = DATA_ACK;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                        sda_out_d = 1'b0;
                    end else begin
                        sda_out_d = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            DATA_ACK: begin
                if (tick) begin
                    sda_oe_d  = 1'b0;
                    sda_out_d = 1'b0;
                    if (!dir_q && nack_c) begin
                        ack_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        byte_cnt_d = next_byte_c;
                        if (next_byte_c < count_q) begin
                            load_byte = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                sda_oe_d  = 1'b0;
                sda_out_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Open a data frame; write bytes are consumed from the bottom of tx_q.
        if (load_byte) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            if (!dir_q) begin
                sda_oe_d  = 1'b1;
                sda_out_d = tx_q[7];
                shift_d   = {tx_q[6:0], 1'b0};
                tx_d      = tx_q >> BITS_PER_BYTE;
            end else begin
                sda_oe_d  = 1'b0;
                sda_out_d = 1'b0;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            count_q    <= '0;
            dir_q      <= 1'b0;
            shift_q    <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sda_out_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            sda_out_q  <= sda_out_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign sda_out       = sda_out_q;
    assign sda_oe        = sda_oe_q;
    assign busy          = busy_q;
    assign transfer_done = done_q;
    assign ack_error     = ack_err_q;
    assign rx_data       = rx_q;

endmodule

// File: tb/tb_i2c_burst_engine.sv
// Directed bench for i2c_burst_engine: per-tick SDA/busy/done scoreboard plus
// end-of-burst ack_error and rx_data checks.
module tb_i2c_burst_engine;

    localparam int unsigned MAXB = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned DW   = 8 * MAXB;
`ifdef I2C_BURST_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          timebase;
    logic          start;
    logic          direction;
    logic [6:0]    slave_address;
    logic [CW-1:0] n_bytes;
    logic [DW-1:0] tx_data;
    logic          sda_in;
    logic          sda_out;
    logic          sda_oe;
    logic          busy;
    logic          transfer_done;
    logic          ack_error;
    logic [DW-1:0] rx_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];
    logic       sin_q[$];

    i2c_burst_engine #(.MAX_BYTES(MAXB), .CNT_W(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .timebase      (timebase),
        .start         (start),
        .direction     (direction),
        .slave_address (slave_address),
        .n_bytes       (n_bytes),
        .tx_data       (tx_data),
        .sda_in        (sda_in),
        .sda_out       (sda_out),
        .sda_oe        (sda_oe),
        .busy          (busy),
        .transfer_done (transfer_done),
        .ack_error     (ack_error),
        .rx_data       (rx_data)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One timebase rising edge; returns {busy, oe, oe&out, done} one clock later.
    task automatic pulse_tick(input logic sin, output logic [3:0] obs);
        sda_in   = sin;
        timebase = 1'b1;
        @(posedge clock); #1;
        timebase = 1'b0;
        @(negedge clock);
        obs = {busy, sda_oe, sda_oe & sda_out, transfer_done};
        @(posedge clock); #1;
    endtask

    task automatic run_burst(input string tag, input logic dir, input logic [6:0] addr,
                             input logic [CW-1:0] n, input logic [DW-1:0] tx,
                             input logic [DW-1:0] slave, input logic addr_nack,
                             input bit tick_at_start, input int disturb, input int stop_at);
        int         c;
        int         nf;
        bit         early;
        bit         rd;
        logic [7:0] fb;
        logic [7:0] nb;
        logic [3:0] obs;
        logic [3:0] e;
        logic       s;
        logic [DW-1:0] exp_rx;

        c      = (int'(n) > int'(MAXB)) ? int'(MAXB) : int'(n);
        early  = ACK_CHK && addr_nack;
        nf     = early ? 1 : 1 + c;
        exp_rx = '0;

        for (int f = 0; f < nf; f++) begin
            fb = (f == 0) ? {addr, dir} : tx[8*(f-1) +: 8];
            rd = (f > 0) && dir;
            for (int j = 1; j <= 8; j++) begin
                sin_q.push_back(rd ? slave[8*(f-1) + 8 - j] : 1'b1);
                if (j < 8)
                    exp_q.push_back(rd ? 4'b1000 : {2'b11, fb[7-j], 1'b0});
                else
                    exp_q.push_back(rd ? {2'b11, (f == c), 1'b0} : 4'b1000);
            end
            sin_q.push_back((f == 0) ? addr_nack : rd);
            if (f < nf - 1) begin
                nb = tx[8*f +: 8];
                exp_q.push_back(dir ? 4'b1000 : {2'b11, nb[7], 1'b0});
            end else begin
                exp_q.push_back(4'b1001);
            end
            if (rd) exp_rx[8*(f-1) +: 8] = slave[8*(f-1) +: 8];
        end

        slave_address = addr;
        direction     = dir;
        n_bytes       = n;
        tx_data       = tx;
        start         = 1'b1;
        timebase      = tick_at_start;
        @(posedge clock); #1;
        start    = 1'b0;
        timebase = 1'b0;
        @(negedge clock);
        check({tag, "/start"}, 64'({busy, sda_oe, sda_oe & sda_out, transfer_done}),
              64'({3'b111 & {2'b11, addr[6]}, 1'b0}));
        check({tag, "/start_clr"}, 64'({ack_error, rx_data}), 64'(0));
        @(posedge clock); #1;

        for (int t = 1; t <= 9 * nf; t++) begin
            if (t == disturb) begin
                slave_address = 7'h3c;
                direction     = ~dir;
                n_bytes       = CW'(1);
                tx_data       = ~tx;
                start         = 1'b1;
                @(posedge clock); #1;
                start = 1'b0;
            end
            s = sin_q.pop_front();
            pulse_tick(s, obs);
            e = exp_q.pop_front();
            check($sformatf("%s/tick%0d", tag, t), 64'(obs), 64'(e));
            if (t == stop_at) break;
        end
        exp_q.delete();
        sin_q.delete();

        if (stop_at == 0) begin
            @(negedge clock);
            check({tag, "/idle"}, 64'({busy, transfer_done, sda_oe}), 64'(0));
            check({tag, "/ack_error"}, 64'(ack_error), 64'(early));
            check({tag, "/rx"}, 64'(rx_data), 64'(exp_rx));
            repeat (3) @(negedge clock);
            check({tag, "/rx_hold"}, 64'(rx_data), 64'(exp_rx));
            @(posedge clock); #1;
        end
    endtask

    initial begin
        reset         = 1'b1;
        timebase      = 1'b0;
        start         = 1'b0;
        direction     = 1'b0;
        slave_address = '0;
        n_bytes       = '0;
        tx_data       = '0;
        sda_in        = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset", 64'({busy, transfer_done, sda_oe, sda_out, ack_error, rx_data}), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;

        run_burst("write",   1'b0, 7'h50, CW'(2),  32'h0000BEEF, 32'h0,        1'b0, 1'b0, 0,  0);
        run_burst("read",    1'b1, 7'h51, CW'(3),  32'h0,        32'h00563412, 1'b0, 1'b1, 0,  0);
        run_burst("read1",   1'b1, 7'h11, CW'(1),  32'h0,        32'hAAAAAA9C, 1'b0, 1'b0, 0,  0);
        run_burst("nack",    1'b0, 7'h22, CW'(4),  32'h01020304, 32'h0,        1'b1, 1'b0, 0,  0);
        run_burst("n0",      1'b0, 7'h7f, CW'(0),  32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 0,  0);
        run_burst("n15",     1'b0, 7'h0d, CW'(15), 32'h11223344, 32'h0,        1'b0, 1'b0, 0,  0);
        run_burst("disturb", 1'b0, 7'h0a, CW'(2),  32'h0000A5C3, 32'h0,        1'b0, 1'b0, 14, 0);

        run_burst("rst_mid", 1'b1, 7'h33, CW'(2),  32'h0,        32'h0000FFFF, 1'b0, 1'b0, 0,  12);
        reset         = 1'b1;
        start         = 1'b1;
        slave_address = 7'h44;
        direction     = 1'b0;
        n_bytes       = CW'(1);
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check("rst_mid/reset", 64'({busy, transfer_done, sda_oe, sda_out, ack_error, rx_data}), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid/no_start", 64'({busy, sda_oe}), 64'(0));
        @(posedge clock); #1;
        run_burst("post_rst", 1'b0, 7'h2a, CW'(1), 32'h0000005A, 32'h0,        1'b0, 1'b0, 0,  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
